// File: rtl/apb_requester.sv
// APB4 requester: converts a valid/ready command stream into APB transfers,
// with a one-entry skid buffer, PSLVERR reporting and an ACCESS-phase timeout.
module apb_requester #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  output logic [2:0]            pprot,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_e;

  state_e                state_q, state_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic [2:0]            pprot_q, pprot_d;

  logic                  buf_full_q, buf_full_d;
  logic                  buf_write_q, buf_write_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_WIDTH-1:0] buf_wdata_q, buf_wdata_d;
  logic [STRB_WIDTH-1:0] buf_strb_q, buf_strb_d;
  logic [2:0]            buf_prot_q, buf_prot_d;

  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic cmd_hs;
  logic timeout_hit;
  logic load_cmd;
  logic load_buf;
  logic fill_buf;

  assign cmd_ready   = presetn & ~buf_full_q;
  assign cmd_hs      = cmd_valid & cmd_ready;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d       = state_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    buf_full_d    = buf_full_q;
    buf_write_d   = buf_write_q;
    buf_addr_d    = buf_addr_q;
    buf_wdata_d   = buf_wdata_q;
    buf_strb_d    = buf_strb_q;
    buf_prot_d    = buf_prot_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    load_cmd      = 1'b0;
    load_buf      = 1'b0;
    fill_buf      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
          load_cmd = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d  = S_ACCESS;
        cnt_d    = '0;
        fill_buf = cmd_hs;
      end
      S_ACCESS: begin
        if (pready || timeout_hit) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = (pready && !pwrite_q) ? prdata : '0;
          rsp_err_d     = pready ? pslverr : 1'b1;
          rsp_timeout_d = !pready;
          // A full buffer keeps cmd_ready low, so no handshake can race it here.
          if (buf_full_q) begin
            load_buf = 1'b1;
            state_d  = S_SETUP;
          end else if (cmd_hs) begin
            load_cmd = 1'b1;
            state_d  = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d    = cnt_q + CW'(1);
          fill_buf = cmd_hs;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_cmd) begin
      pwrite_d = cmd_write;
      paddr_d  = cmd_addr;
      pwdata_d = cmd_write ? cmd_wdata : '0;
      pstrb_d  = cmd_write ? cmd_strb : '0;
      pprot_d  = cmd_prot;
    end

    if (load_buf) begin
      pwrite_d   = buf_write_q;
      paddr_d    = buf_addr_q;
      pwdata_d   = buf_wdata_q;
      pstrb_d    = buf_strb_q;
      pprot_d    = buf_prot_q;
      buf_full_d = 1'b0;
    end

    // Read masking happens on entry to the buffer so the drain path is a plain copy.
    if (fill_buf) begin
      buf_full_d  = 1'b1;
      buf_write_d = cmd_write;
      buf_addr_d  = cmd_addr;
      buf_wdata_d = cmd_write ? cmd_wdata : '0;
      buf_strb_d  = cmd_write ? cmd_strb : '0;
      buf_prot_d  = cmd_prot;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= S_IDLE;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      buf_full_q    <= 1'b0;
      buf_write_q   <= 1'b0;
      buf_addr_q    <= '0;
      buf_wdata_q   <= '0;
      buf_strb_q    <= '0;
      buf_prot_q    <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      buf_full_q    <= buf_full_d;
      buf_write_q   <= buf_write_d;
      buf_addr_q    <= buf_addr_d;
      buf_wdata_q   <= buf_wdata_d;
      buf_strb_q    <= buf_strb_d;
      buf_prot_q    <= buf_prot_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign psel        = (state_q != S_IDLE);
  assign penable     = (state_q == S_ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: table of commands with a scoreboard of
// expected responses, a wait-state completer model, and hand-written corner sequences.
module tb_apb_requester;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;

  always #5 pclk = ~pclk;

  apb_requester #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .STRB_WIDTH(4),
    .TIMEOUT   (4)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    bit          b2b;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          ws;      // ACCESS cycles before PREADY; -1 = never
    bit          slverr;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          exp_to;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          to;
    int          lat;
    longint      hs;
  } exp_t;

  typedef struct {
    int          ws;
    bit          slverr;
    logic [31:0] rdata;
    logic [71:0] fields;
  } cpl_t;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  exp_t   sbq[$];
  cpl_t   cq[$];
  logic [2:0] trace [0:4095];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit b2b, bit wr, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] strb, logic [2:0] prot, int ws, bit se,
                              logic [31:0] rd, logic [31:0] erd, bit ee, bit et, int el);
    vec_t v;
    v.b2b = b2b; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
    v.ws = ws; v.slverr = se; v.rdata = rd;
    v.exp_rdata = erd; v.exp_err = ee; v.exp_to = et; v.exp_lat = el;
    return v;
  endfunction

  always @(posedge pclk) cyc <= cyc + 1;

  // Completer model: pops one behaviour per SETUP phase and checks field stability.
  initial begin
    cpl_t cur;
    int   acc;
    bit   have;
    bit   rdy;
    have = 0; acc = 0;
    cur.ws = 0; cur.slverr = 0; cur.rdata = '0; cur.fields = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        have = 0;
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      end else if (psel && !penable) begin
        if (cq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_setup: psel=1 with no command outstanding, required psel=0");
          have = 0;
        end else begin
          cur = cq.pop_front();
          have = 1; acc = 0;
          chk("apb_setup_fields", {pwrite, paddr, pwdata, pstrb, pprot}, cur.fields);
        end
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      end else if (psel && penable) begin
        if (have) chk("apb_access_fields", {pwrite, paddr, pwdata, pstrb, pprot}, cur.fields);
        rdy = have && (cur.ws >= 0) && (acc == cur.ws);
        pready  = rdy;
        pslverr = rdy ? cur.slverr : 1'($urandom);
        prdata  = rdy ? cur.rdata : $urandom;
        acc++;
      end else begin
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      end
    end
  end

  // Response monitor / scoreboard and bus trace.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (cyc < 4096) trace[cyc] = {psel, penable, cmd_ready};
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: rsp_valid=1 required 0 at cycle %0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_timeout", rsp_timeout, e.to);
          chk("rsp_latency", cyc - e.hs, e.lat);
        end
      end
    end
  end

  task automatic send(input vec_t v, output longint hs);
    exp_t e;
    cpl_t c;
    int   n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_strb = v.strb; cmd_prot = v.prot;
    while (!cmd_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_ready_wait: cmd_ready=0 for 50 cycles, required 1");
      hs = -1;
      cmd_valid = 1'b0;
      return;
    end
    hs = cyc + 1;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.to = v.exp_to; e.lat = v.exp_lat; e.hs = hs;
    sbq.push_back(e);
    c.ws = v.ws; c.slverr = v.slverr; c.rdata = v.rdata;
    c.fields = {v.wr, v.addr, (v.wr ? v.wdata : 32'h0), (v.wr ? v.strb : 4'h0), v.prot};
    cq.push_back(c);
    @(negedge pclk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom;
    cmd_wdata = $urandom; cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || psel) && n < 200) begin
      @(negedge pclk);
      n++;
    end
    if (sbq.size() != 0 || psel) begin
      checks++; errors++;
      $display("FAIL idle_wait: %0d responses outstanding, psel=%0b after 200 cycles, required 0/0",
               sbq.size(), psel);
    end
  endtask

  initial begin
    vec_t   vecs[11];
    vec_t   v;
    longint h1, h2;
    logic [2:0] exp_tr [0:4];

    vecs[0]  = mk(0, 1, 32'h8,   32'hDEADBEEF, 4'b0101, 3'd0,  0, 0, 32'h0,        32'h0,        0, 0, 2);
    vecs[1]  = mk(0, 0, 32'h10,  32'h11111111, 4'b1111, 3'd1,  3, 0, 32'h12345678, 32'h12345678, 0, 0, 5);
    vecs[2]  = mk(0, 1, 32'h100, 32'hA5A5A5A5, 4'b1111, 3'd2,  0, 0, 32'h0,        32'h0,        0, 0, 2);
    vecs[3]  = mk(1, 0, 32'h104, 32'h0,        4'b0000, 3'd0,  0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 3);
    vecs[4]  = mk(0, 0, 32'h3,   32'h0,        4'b0000, 3'd0,  1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 3);
    vecs[5]  = mk(0, 1, 32'h7,   32'h01020304, 4'b0011, 3'd4,  0, 1, 32'h0,        32'h0,        1, 0, 2);
    vecs[6]  = mk(0, 0, 32'h40,  32'h0,        4'b0000, 3'd0, -1, 0, 32'h55AA55AA, 32'h0,        1, 1, 5);
    vecs[7]  = mk(1, 1, 32'h44,  32'h87654321, 4'b1000, 3'd5,  0, 0, 32'h0,        32'h0,        0, 0, 6);
    vecs[8]  = mk(0, 0, 32'h48,  32'h0,        4'b0000, 3'd3,  4, 0, 32'h99999999, 32'h0,        1, 1, 5);
    vecs[9]  = mk(0, 1, 32'h50,  32'h0BADF00D, 4'b0110, 3'd7,  2, 0, 32'h0,        32'h0,        0, 0, 4);
    vecs[10] = mk(1, 0, 32'h54,  32'h0,        4'b0000, 3'd6,  0, 0, 32'h13579BDF, 32'h13579BDF, 0, 0, 5);

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_bus", {psel, penable, pwrite, paddr, pwdata, pstrb, pprot}, '0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, '0);
    presetn = 1'b1;
    #1 chk("cmd_ready_after_reset", cmd_ready, 1'b1);
    @(negedge pclk);

    for (int i = 0; i < 11; i++) begin
      if (!vecs[i].b2b) wait_idle();
      send(vecs[i], h1);
    end
    wait_idle();

    // Back-to-back: psel holds, penable gaps once, cmd_ready low while buffered.
    v = mk(0, 1, 32'h200, 32'hFEEDFACE, 4'b1111, 3'd1, 0, 0, 32'h0, 32'h0, 0, 0, 2);
    send(v, h1);
    v = mk(1, 0, 32'h204, 32'h0, 4'b0000, 3'd1, 0, 0, 32'h2468ACE0, 32'h2468ACE0, 0, 0, 3);
    send(v, h2);
    wait_idle();
    @(negedge pclk);
    exp_tr[0] = 3'b101; exp_tr[1] = 3'b110; exp_tr[2] = 3'b101; exp_tr[3] = 3'b111; exp_tr[4] = 3'b001;
    chk("b2b_hs_spacing", h2 - h1, 1);
    if (h1 >= 0 && h1 + 4 < 4096)
      for (int k = 0; k < 5; k++) chk($sformatf("b2b_trace_%0d", k), trace[h1 + k], exp_tr[k]);

    // Reset mid-ACCESS with a command buffered: everything is dropped silently.
    v = mk(0, 0, 32'h300, 32'h0, 4'b0000, 3'd0, -1, 0, 32'h0, 32'h0, 1, 1, 5);
    send(v, h1);
    v = mk(1, 1, 32'h304, 32'h77777777, 4'b1111, 3'd0, 0, 0, 32'h0, 32'h0, 0, 0, 6);
    send(v, h2);
    chk("pre_reset_access", {psel, penable, cmd_ready}, 3'b110);
    #2 presetn = 1'b0;
    sbq.delete();
    cq.delete();
    #1 chk("rst_mid_access", {psel, penable, rsp_valid, cmd_ready}, 4'b0000);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    #1 chk("cmd_ready_release", cmd_ready, 1'b1);
    repeat (12) @(negedge pclk);
    chk("no_restart_after_reset", {psel, penable}, 2'b00);

    v = mk(0, 0, 32'h400, 32'h0, 4'b0000, 3'd0, 0, 0, 32'h0F0F0F0F, 32'h0F0F0F0F, 0, 0, 2);
    send(v, h1);
    wait_idle();
    chk("scoreboard_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
